mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory responder for the core's load/store port: accepts one word request at a time over a
//   valid/ready channel and returns read data on a separate valid/ready response channel.
//   Models a word-organised RAM with byte-write strobes and a fixed number of wait states.
//   Sits between the core's memory-address/write-data path and the data store.
//   It replaces the zero-latency array so the control FSM can be exercised against real stalls.
// PARAMETERS
//   DEPTH_WORDS  1024         number of 32-bit words; must be a power of two
//   WAIT_STATES  2            extra cycles between acceptance and response (0..15)
//   BASE_ADDR    32'h0000_0000 byte address mapped to word 0
// PORTS
//   clk        in   1   clock; all logic on posedge
//   reset      in   1   synchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_addr   in   32  byte address
//   req_we     in   1   1 = write, 0 = read
//   req_wstrb  in   4   byte enables for writes; bit i enables wdata[8i+7:8i]
//   req_wdata  in   32  write data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester takes the response
//   rsp_rdata  out  32  read data; 0 for writes
//   rsp_err    out  1   error flag; see CONFIGURATION
// BEHAVIOUR
//   - FSM states: IDLE, WAIT, RESP. Memory array contents are not reset.
//   - Reset (and the cycle it is sampled): state goes to IDLE, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0. req_ready is 0 while reset is high.
//   - IDLE: req_ready=1 (combinational from state). On req_valid&&req_ready the responder latches
//     addr, we, wstrb and wdata, and loads a wait counter with WAIT_STATES.
//       If WAIT_STATES==0: the access is performed at the same edge and the state goes to RESP.
//       Otherwise: the state goes to WAIT.
//   - WAIT: req_ready=0. The counter decrements each cycle. At the edge where counter==1, the
//     access is performed and the state goes to RESP.
//   - Access:
//       word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS; addr[1:0] is ignored.
//       Write: only the bytes enabled in wstrb are updated. wstrb==0 is a no-op but still
//         responds. rsp_rdata is set to 0.
//       Read: rsp_rdata is registered from the array.
//   - Latency: rsp_valid is first high WAIT_STATES+1 cycles after the accepting cycle.
//   - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err are held stable until
//     rsp_valid&&rsp_ready. On that handshake: rsp_valid goes to 0 and the state goes to IDLE.
//     A new request is accepted no earlier than the following cycle (no back-to-back overlap).
//   - rsp_ready may be high before rsp_valid; the handshake is still only on the RESP cycle.
//   - req_* inputs are ignored outside IDLE. Changing them after acceptance has no effect.
//   - Reset mid-WAIT: the request is dropped and no write occurs.
//     Reset in RESP: the response is dropped, but a write already performed persists.
//   - Address wrap: index arithmetic is modulo DEPTH_WORDS; (addr - BASE_ADDR) wraps mod 2^32.
// CONFIGURATION
//   MEM_RESP_ERR_EN defined:
//     A request with addr[1:0]!=0 is an error.
//     A request with (addr - BASE_ADDR) >= 4*DEPTH_WORDS (unsigned) is an error.
//     On error: no array write, rsp_rdata=0, rsp_err=1. Timing is unchanged.
//   MEM_RESP_ERR_EN undefined:
//     rsp_err is constant 0, the low address bits are ignored, and out-of-range
//     addresses alias via the wrap rule.
// TESTING
//   1 WAIT_STATES=2: write 0xDEADBEEF to 0x10 (wstrb=4'hF), then read 0x10
//     -> each rsp_valid appears exactly 3 cycles after acceptance; read data = 0xDEADBEEF.
//   2 Preload 0x11223344 at 0x20, write wstrb=4'b0101 wdata=0xAABBCCDD, read 0x20
//     -> read data = 0x11BB33DD.
//   3 Hold rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid stays 1 and rsp_rdata stays stable; req_ready=0 throughout;
//        IDLE is reached the cycle after rsp_ready rises.
//   4 WAIT_STATES=0, req_valid held high with rsp_ready=1
//     -> accepts occur every 2 cycles; responses follow one cycle after each accept.
//   5 Assert reset during WAIT of a write to 0x40 (old value 0x0)
//     -> rsp_valid never rises; a later read of 0x40 returns 0x0.
//   6 MEM_RESP_ERR_EN, DEPTH_WORDS=1024: read 0x1002, then write 0x1000
//     -> both give rsp_err=1 and rsp_rdata=0; a read of 0x0 is unchanged.
//     Without the macro: 0x1000 aliases to word 0 and rsp_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word RAM behind valid/ready request/response channels with fixed wait states; optional address error checks under MEM_RESP_ERR_EN
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic we_q, we_d, err_q, err_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d, off;
  logic accept, access;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  // Request capture (live inputs on accept so a zero-wait access sees them), wait countdown and response generation.
  always_comb begin
    off         = req_addr - BASE_ADDR;
    accept      = req_valid && req_ready;
    idx_d       = accept ? off[AW+1:2] : idx_q;
    we_d        = accept ? req_we : we_q;
    wstrb_d     = accept ? req_wstrb : wstrb_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    err_d       = accept ? ERR_EN && ((|req_addr[1:0]) || ({32'b0, off} >= 64'(DEPTH_WORDS) * 64'd4)) : err_q;
    access      = !reset && ((accept && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == 4'd1));
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      cnt_d   = 4'(WAIT_STATES);
      state_d = (WAIT_STATES == 0) ? RESP : WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
    end
    if (state_q == RESP && rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
    if (access) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (we_d || err_d) ? 32'h0 : mem[idx_d];
      rsp_err_d   = err_d;
    end
  end
  // FSM state and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
    idx_q   <= idx_d;
    we_q    <= we_d;
    wstrb_q <= wstrb_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end
  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (access && we_d && !err_d)
      for (int i = 0; i < 4; i++)
        if (wstrb_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus stall, reset and zero-wait sequences for mem_responder
module tb_mem_responder;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic b_req_valid = 1'b0, b_rsp_ready = 1'b0, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(32'h0), .req_we(1'b0), .req_wstrb(4'h0), .req_wdata(32'h0),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  vec_t v[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_addr = a; req_we = we; req_wstrb = s; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_we = ~we; req_wstrb = ~s;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_req(input int k);
    int lat;
    send(v[k].a, v[k].we, v[k].s, v[k].d);
    rsp_ready = 1'b1;
    wait_rsp(lat);
    chk($sformatf("lat[%0d]", k), 32'(lat), 32'd3);
    chk($sformatf("rdata[%0d]", k), rsp_rdata, v[k].er);
    chk($sformatf("err[%0d]", k), 32'(rsp_err), 32'(v[k].ee));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("valid_drop[%0d]", k), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat, seen;
    v[0]  = '{32'h10,   1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{32'h10,   1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{32'h20,   1'b1, 4'hF, 32'h11223344, 32'h0,        1'b0};
    v[3]  = '{32'h20,   1'b1, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
    v[4]  = '{32'h20,   1'b0, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    v[5]  = '{32'h24,   1'b1, 4'hF, 32'h12345678, 32'h0,        1'b0};
    v[6]  = '{32'h24,   1'b1, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    v[7]  = '{32'h24,   1'b0, 4'h0, 32'h0,        32'h12345678, 1'b0};
    v[8]  = '{32'h0,    1'b1, 4'hF, 32'h0,        32'h0,        1'b0};
    v[9]  = '{32'h40,   1'b1, 4'hF, 32'h0,        32'h0,        1'b0};
    v[10] = '{32'hFFC,  1'b1, 4'hF, 32'h55AA55AA, 32'h0,        1'b0};
    v[11] = '{32'hFFC,  1'b0, 4'h0, 32'h0,        32'h55AA55AA, 1'b0};
    v[12] = '{32'h1002, 1'b0, 4'h0, 32'h0,        32'h0,        ERR};
    v[13] = '{32'h1000, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0,        ERR};
    v[14] = '{32'h0,    1'b0, 4'h0, 32'h0,        ERR ? 32'h0 : 32'hCAFEF00D, 1'b0};
    v[15] = '{32'h1002, 1'b0, 4'h0, 32'h0,        ERR ? 32'h0 : 32'hCAFEF00D, ERR};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 16; k++) do_req(k);
    send(32'h10, 1'b0, 4'h0, 32'h0);
    wait_rsp(lat);
    chk("stall_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_idle_ready", 32'(req_ready), 32'd1);
    chk("stall_valid_drop", 32'(rsp_valid), 32'd0);
    send(32'h40, 1'b1, 4'hF, 32'h99999999);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("rst_wait_no_rsp", 32'(seen), 32'd0);
    v[0] = '{32'h40, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
    do_req(0);
    @(negedge clk);
    b_req_valid = 1'b1;
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("ws0_ready[%0d]", i), 32'(b_req_ready), 32'(i % 2 == 0));
      chk($sformatf("ws0_valid[%0d]", i), 32'(b_rsp_valid), 32'(i % 2 == 1));
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
